// File: rtl/seg_pkg.sv
// Shared definitions for the four-digit seven-segment multiplexer:
// segment pattern table, all-off constants and the scan state encoding.
package seg_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n is hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        return HEX_SEG[h];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure table lookup.
    always_comb begin
        seg_o = hex_to_seg(hex_i);
    end

endmodule

// File: rtl/seg_mux4.sv
// Four-digit time-multiplexed seven-segment driver. Each digit is lit for
// 2^PRESCALE_W clocks, separated by DEAD_CYCLES all-off clocks. Display data
// is latched once per frame so a frame never mixes two input words.
module seg_mux4
    import seg_pkg::*;
#(
    parameter int PRESCALE_W  = 16,
    parameter int DEAD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] disp_datain,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [15:0]           data_q, data_d;
    logic [3:0]            dpsh_q, dpsh_d;
    logic [3:0]            blank_q, blank_d;

    logic [3:0]            an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic                  tick_d;
    logic [3:0]            nib;
    logic [6:0]            nib_seg;

    // Outputs are computed from next-state values so they switch on the
    // same edge as the state/index change that causes them.
    assign nib = data_d[{idx_d, 2'b00} +: 4];

    hex7seg u_dec (
        .hex_i (nib),
        .seg_o (nib_seg)
    );

    // Next-state: dead/on sequencing, digit advance and frame capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        pre_d   = pre_q;
        data_d  = data_q;
        dpsh_d  = dpsh_q;
        blank_d = blank_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_DEAD: begin
                if (dcnt_q == DEAD_LAST) begin
                    state_d = ST_ON;
                    idx_d   = idx_q + 2'd1;
                    pre_d   = '0;
                    if (idx_d == 2'd0) begin
                        data_d  = disp_datain;
                        dpsh_d  = dp_in;
                        blank_d = blank_in;
                        tick_d  = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            default: begin
                if (&pre_q) begin
                    state_d = ST_DEAD;
                    dcnt_d  = '0;
                end else begin
                    pre_d = pre_q + PRESCALE_W'(1);
                end
            end
        endcase
    end

    // Output next values: one anode low only while a non-blanked digit is on.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == ST_ON && !blank_d[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = nib_seg;
            dp_d        = ~dpsh_d[idx_d];
        end
    end

    // State, counters, shadow registers and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_DEAD;
            idx_q      <= 2'd3;
            dcnt_q     <= '0;
            pre_q      <= '0;
            data_q     <= '0;
            dpsh_q     <= '0;
            blank_q    <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dcnt_q     <= dcnt_d;
            pre_q      <= pre_d;
            data_q     <= data_d;
            dpsh_q     <= dpsh_d;
            blank_q    <= blank_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg_mux4.sv
// Directed bench for seg_mux4 with PRESCALE_W=3, DEAD_CYCLES=2:
// digit period 10 clocks, frame period 40 clocks.
module tb_seg_mux4;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] disp_datain;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;

    localparam logic [6:0] EXP_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg_mux4 #(.PRESCALE_W(3), .DEAD_CYCLES(2)) dut (
        .clk         (clk),
        .clr         (clr),
        .disp_datain (disp_datain),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        k += n;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic dp_e, input logic tk_e);
        chk({tag, ".an"},   16'(an),         16'(an_e));
        chk({tag, ".seg"},  16'(seg),        16'(seg_e));
        chk({tag, ".dp"},   16'(dp),         16'(dp_e));
        chk({tag, ".tick"}, 16'(frame_tick), 16'(tk_e));
    endtask

    task automatic wait_tick(input string tag, output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (frame_tick !== 1'b1 && cycles < 100);
        chk({tag, ".tick_seen"}, 16'(frame_tick), 16'd1);
    endtask

    initial begin
        int cyc;
        int lit;
        logic [3:0] v4;

        clr         = 1'b1;
        disp_datain = 16'h1234;
        dp_in       = 4'b0000;
        blank_in    = 4'b0000;
        step(2);
        chk_out("reset", 4'hF, 7'h7F, 1'b1, 1'b0);

        // Release and first frame.
        clr = 1'b0;
        k   = 0;
        step(1);
        chk_out("k1_dead", 4'hF, 7'h7F, 1'b1, 1'b0);
        step(1);
        chk_out("k2_dig0", 4'b1110, 7'b0011001, 1'b1, 1'b1);
        step(1);
        chk_out("k3_dig0", 4'b1110, 7'b0011001, 1'b1, 1'b0);
        step(6);
        chk_out("k9_dig0", 4'b1110, 7'b0011001, 1'b1, 1'b0);
        step(1);
        chk_out("k10_dead", 4'hF, 7'h7F, 1'b1, 1'b0);
        step(1);
        chk_out("k11_dead", 4'hF, 7'h7F, 1'b1, 1'b0);
        step(1);
        chk_out("k12_dig1", 4'b1101, 7'b0110000, 1'b1, 1'b0);

        // New word mid-frame must not reach the current frame.
        disp_datain = 16'hABCD;
        step(10);
        chk_out("k22_dig2_old", 4'b1011, 7'h24, 1'b1, 1'b0);
        step(10);
        chk_out("k32_dig3_old", 4'b0111, 7'h79, 1'b1, 1'b0);

        blank_in = 4'b0100;
        dp_in    = 4'b0001;
        step(10);
        chk_out("k42_dig0_new", 4'b1110, 7'h21, 1'b0, 1'b1);
        step(8);
        chk_out("k50_dead_dp", 4'hF, 7'h7F, 1'b1, 1'b0);
        step(2);
        chk_out("k52_dig1", 4'b1101, 7'h46, 1'b1, 1'b0);
        step(10);
        chk_out("k62_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
        step(7);
        chk_out("k69_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
        step(3);
        chk_out("k72_dig3", 4'b0111, 7'h08, 1'b1, 1'b0);
        step(2);
        chk_out("k74_dig3", 4'b0111, 7'h08, 1'b1, 1'b0);

        // Asynchronous clear mid-ON.
        #2 clr = 1'b1;
        #1 chk_out("clr_async", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        k   = 0;
        step(1);
        chk_out("rst2_k1", 4'hF, 7'h7F, 1'b1, 1'b0);
        step(1);
        chk_out("rst2_k2", 4'b1110, 7'h21, 1'b0, 1'b1);
        wait_tick("period1", cyc);
        chk("period1.cycles", 16'(cyc), 16'd40);
        wait_tick("period2", cyc);
        chk("period2.cycles", 16'(cyc), 16'd40);

        // Sweep every nibble value into every digit.
        blank_in = 4'b0000;
        dp_in    = 4'b0000;
        for (int v = 0; v < 16; v++) begin
            v4 = 4'(v);
            disp_datain = {v4, v4, v4, v4};
            wait_tick("sweep", cyc);
            lit = 0;
            for (int c = 0; c < 40; c++) begin
                if (c > 0) step(1);
                chk($sformatf("sweep%0d.an_onehot", v), 16'($countones(~an) <= 1), 16'd1);
                if (an !== 4'hF) begin
                    lit++;
                    chk($sformatf("sweep%0d.seg", v), 16'(seg), 16'(EXP_SEG[v]));
                end
            end
            chk($sformatf("sweep%0d.lit", v), 16'(lit), 16'd32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_mux4.md
SEG_MUX4 -- requirements
Module: seg_mux4

Interface
REQ-001 Parameter PRESCALE_W, default 16: width of the ON-time counter; each digit is lit for 2^PRESCALE_W clocks.
REQ-002 Parameter DEAD_CYCLES, default 32, legal range 1..255: number of all-off clocks inserted between digits.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 disp_datain  in  16  four hex nibbles; [3:0] is the rightmost digit (digit 0), [15:12] is the leftmost.
REQ-006 dp_in  in  4  decimal-point request per digit, active-high; bit n belongs to digit n.
REQ-007 blank_in  in  4  blank request per digit, active-high.
REQ-008 an  out  4  digit anodes, active-low; an[n] drives digit n.
REQ-009 seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  out  1  decimal-point cathode, active-low.
REQ-011 frame_tick  out  1  one-clock pulse at each frame capture.

Function
REQ-012 FSM states: DEAD and ON; a 2-bit digit index 0..3, incremented with wrap 3->0.
REQ-013 DEAD: an=4'hF, seg=7'h7F, dp=1; the dead counter counts 0..DEAD_CYCLES-1.
REQ-014 On the edge where the dead counter = DEAD_CYCLES-1, the block enters ON, increments the digit index and clears the prescaler.
REQ-015 ON: the prescaler counts 0..2^PRESCALE_W-1; on the edge where it is all-ones, the block enters DEAD and clears the dead counter.
REQ-016 ON outputs:
- an = 4'hF except an[idx] = 0.
- seg = decode(shadow nibble idx).
- dp = ~shadow_dp[idx].
REQ-017 A blanked digit (shadow_blank[idx] = 1) during ON gives an=4'hF, seg=7'h7F, dp=1; timing is unchanged.
REQ-018 Frame capture happens on the DEAD->ON edge whose new index is 0:
- disp_datain, dp_in and blank_in are registered into the shadow registers.
- frame_tick = 1 for exactly that one cycle.
REQ-019 Input changes between captures have no effect until the next capture, so a frame never mixes two data words.
REQ-020 All outputs are registered; each output changes on the same edge as the state or index change that causes it.
REQ-021 Timing figures:
- Digit period = 2^PRESCALE_W + DEAD_CYCLES clocks.
- frame_tick period = 4 × the digit period.
- First frame_tick comes DEAD_CYCLES clocks after clr deasserts.
REQ-022 Decode, active-low g..a (full table is in the package):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
REQ-023 No two anodes are ever low in the same cycle, and every digit change passes through DEAD.

Reset
REQ-024 clr=1 forces the following immediately, without waiting for a clock edge:
- State DEAD with digit index 3.
- Dead counter and prescaler at 0.
- Shadow registers at 0.
- an=4'hF, seg=7'h7F, dp=1, frame_tick=0.
REQ-025 clr asserted in any state aborts the current digit; after clr deasserts, operation restarts as from power-up (REQ-021).

Structure
REQ-026 Shared package seg_pkg holds:
- the 16-entry hex-to-segment pattern table;
- SEG_OFF=7'h7F and AN_OFF=4'hF;
- the state enumeration.
REQ-027 Decoding is done in one combinational sub-module, hex7seg (4-bit in, 7-bit active-low out), instantiated once and fed the nibble selected by the digit index.

Verification (bench parameters PRESCALE_W=3, DEAD_CYCLES=2)
REQ-028 Reset, then disp_datain=16'h1234:
- 2 clocks after release: an=1110, seg=0011001, one frame_tick.
- 8 clocks later: an=1111 for 2 clocks.
- Then: an=1101, seg=0110000.
REQ-029 Change disp_datain to 16'hABCD while digit 1 is lit:
- Digits 2 and 3 still show 2 and 1.
- The next frame's digit 0 shows d (0100001).
REQ-030 blank_in=4'b0100: during the digit-2 ON slot an=1111 and seg=7F, and the slot still lasts 8 clocks.
REQ-031 dp_in=4'b0001: dp=0 only during the digit-0 ON slots and 1 everywhere else.
REQ-032 Assert clr for 1 clock mid-ON:
- an=F and seg=7F in the same cycle, without waiting for a clock edge.
- After release, frame_tick follows 2 clocks later.
- Consecutive frame_ticks are 40 clocks apart.
REQ-033 Sweep disp_datain over all 16 nibble values in every digit; every lit seg matches the REQ-022 table, and an never has more than one 0.
